raptor64_div_seq: RTL and testbench

Divide sequencer between the Raptor64 execute stage and the 64-bit iterative divider. It accepts DIV/MOD ops (register or immediate form), launches the divider with a one-cycle load, stalls the pipeline while the divider runs, and selects quotient or remainder. It then delivers a single-cycle writeback or divide-by-zero exception. A one-entry result cache returns repeated identical divides in one cycle, and a watchdog flags a divider that never completes.

---
 rtl/raptor64_div_seq.sv | 205 ++++++++++++++++++++
 tb/tb_raptor64_div_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/raptor64_div_seq.sv
// Purpose: sequences DIV/MOD ops from execute into the 64-bit iterative divider,
//          with a one-entry result cache, quotient/remainder select and a watchdog.
// Latency: cache hit -> wb_v 1 cycle after issue; miss -> issue + LAUNCH + divider busy + WB
//          (wb_v one cycle after div_done).
// Backpressure: stall holds execute while an op is in flight; issue_v is only sampled in IDLE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_*                  op from execute (op[0] signed, op[1] MOD, op[2] immediate divisor)
//   flush                    squash the in-flight op (divider still runs to completion)
//   stall                    pipeline hold
//   div_*  (out)             load strobe and held operands to the divider
//   div_qo/ro/dvByZr/done    divider results
//   wb_v/wb_tgt/wb_res       single-cycle writeback
//   dbz_exc, tmo_err         divide-by-zero exception / watchdog error pulses
module raptor64_div_seq #(
  parameter logic [7:0] TIMEOUT = 8'd100,
  parameter int         TGTW    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_v,
  input  logic [2:0]      issue_op,
  input  logic [63:0]     issue_a,
  input  logic [63:0]     issue_b,
  input  logic [63:0]     issue_imm,
  input  logic [TGTW-1:0] issue_tgt,
  input  logic            flush,
  output logic            stall,
  output logic            div_ld,
  output logic            div_sgn,
  output logic            div_isDivi,
  output logic [63:0]     div_a,
  output logic [63:0]     div_b,
  output logic [63:0]     div_imm,
  input  logic [63:0]     div_qo,
  input  logic [63:0]     div_ro,
  input  logic            div_dvByZr,
  input  logic            div_done,
  output logic            wb_v,
  output logic [TGTW-1:0] wb_tgt,
  output logic [63:0]     wb_res,
  output logic            dbz_exc,
  output logic            tmo_err
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;

  // latched op
  logic [2:0]      r_op;
  logic [63:0]     r_a, r_b, r_imm;
  logic [TGTW-1:0] r_tgt;

  // one-entry result cache, tagged by dividend, effective divisor and signedness
  logic            r_cv, r_cs;
  logic [63:0]     r_ca, r_cd, r_cq, r_cr;

  logic [7:0]      r_wdog;
  logic            r_wb_v, r_dbz, r_tmo;
  logic [TGTW-1:0] r_wb_tgt;
  logic [63:0]     r_wb_res;

  logic [63:0]     w_issue_div, w_op_div;
  logic            w_accept, w_hit, w_hit_wb, w_wdog_trip;
  logic            w_wb_set, w_dbz_set, w_tmo_set, w_cache_wr, w_cache_inv;

  assign w_issue_div = issue_op[2] ? issue_imm : issue_b;
  assign w_op_div    = r_op[2] ? r_imm : r_b;
  assign w_accept    = (r_state == S_IDLE) && issue_v && !flush;
  assign w_hit       = r_cv && (r_ca == issue_a) && (r_cd == w_issue_div) && (r_cs == issue_op[0]);
  assign w_hit_wb    = w_accept && w_hit;
  // r_wdog counts cycles since LAUNCH; the error pulse is registered, so trip one
  // cycle early to land exactly TIMEOUT cycles after LAUNCH. >= guards the count
  // running past the trip point while a flush moves WAIT to DRAIN.
  assign w_wdog_trip = (r_wdog >= (TIMEOUT - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wb_set    = 1'b0;
    w_dbz_set   = 1'b0;
    w_tmo_set   = 1'b0;
    w_cache_wr  = 1'b0;
    w_cache_inv = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept && !w_hit) w_state_nxt = S_LAUNCH;
      // the divider is already loaded, so a flush here must still drain it
      S_LAUNCH: w_state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          // flush coincident with done: result only reaches the cache
          w_state_nxt = S_IDLE;
          if (div_dvByZr) begin
            w_cache_inv = 1'b1;
            w_dbz_set   = !flush;
          end else begin
            w_cache_wr = 1'b1;
            if (!flush) begin
              w_wb_set    = 1'b1;
              w_state_nxt = S_WB;
            end
          end
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end else if (w_wdog_trip) begin
          w_state_nxt = S_IDLE;
          w_tmo_set   = 1'b1;
          w_cache_inv = 1'b1;
        end
      end
      S_WB:     w_state_nxt = S_IDLE;
      S_DRAIN: begin
        if (div_done) begin
          w_state_nxt = S_IDLE;
          w_cache_wr  = !div_dvByZr;
        end else if (w_wdog_trip) begin
          w_state_nxt = S_IDLE;
          w_tmo_set   = 1'b1;
          w_cache_inv = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_tgt    <= '0;
      r_cv     <= 1'b0;
      r_cs     <= 1'b0;
      r_ca     <= '0;
      r_cd     <= '0;
      r_cq     <= '0;
      r_cr     <= '0;
      r_wdog   <= '0;
      r_wb_v   <= 1'b0;
      r_dbz    <= 1'b0;
      r_tmo    <= 1'b0;
      r_wb_tgt <= '0;
      r_wb_res <= '0;
    end else begin
      r_wb_v <= w_wb_set | w_hit_wb;
      r_dbz  <= w_dbz_set;
      r_tmo  <= w_tmo_set;

      // operands only change in IDLE, so they stay stable while the divider runs
      if (w_accept) begin
        r_op  <= issue_op;
        r_a   <= issue_a;
        r_b   <= issue_b;
        r_imm <= issue_imm;
        r_tgt <= issue_tgt;
      end

      if (w_hit_wb) begin
        r_wb_res <= issue_op[1] ? r_cr : r_cq;
        r_wb_tgt <= issue_tgt;
      end else if (w_wb_set) begin
        r_wb_res <= r_op[1] ? div_ro : div_qo;
        r_wb_tgt <= r_tgt;
      end

      if (w_cache_wr) begin
        r_cv <= 1'b1;
        r_ca <= r_a;
        r_cd <= w_op_div;
        r_cs <= r_op[0];
        r_cq <= div_qo;
        r_cr <= div_ro;
      end else if (w_cache_inv) begin
        r_cv <= 1'b0;
      end

      if (r_state == S_LAUNCH)
        r_wdog <= 8'd1;
      else if ((r_state == S_WAIT) || (r_state == S_DRAIN))
        r_wdog <= r_wdog + 8'd1;
    end
  end

  // WB is the cycle execute resumes and consumes the writeback, so it does not stall
  assign stall      = (r_state != S_IDLE) && (r_state != S_WB);
  assign div_ld     = (r_state == S_LAUNCH);
  assign div_sgn    = r_op[0];
  assign div_isDivi = r_op[2];
  assign div_a      = r_a;
  assign div_b      = r_b;
  assign div_imm    = r_imm;
  assign wb_v       = r_wb_v;
  assign wb_tgt     = r_wb_tgt;
  assign wb_res     = r_wb_res;
  assign dbz_exc    = r_dbz;
  assign tmo_err    = r_tmo;

endmodule

// File: tb/tb_raptor64_div_seq.sv
module tb_raptor64_div_seq;

  localparam int LAT = 64;  // divider busy cycles in the model

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_v;
  logic [2:0]  issue_op;
  logic [63:0] issue_a, issue_b, issue_imm;
  logic [5:0]  issue_tgt;
  logic        flush;
  logic        stall, div_ld, div_sgn, div_isDivi;
  logic [63:0] div_a, div_b, div_imm;
  logic [63:0] div_qo, div_ro;
  logic        div_dvByZr, div_done;
  logic        wb_v;
  logic [5:0]  wb_tgt;
  logic [63:0] wb_res;
  logic        dbz_exc, tmo_err;

  raptor64_div_seq dut (
    .clk(clk), .rst(rst),
    .issue_v(issue_v), .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .issue_imm(issue_imm), .issue_tgt(issue_tgt), .flush(flush),
    .stall(stall), .div_ld(div_ld), .div_sgn(div_sgn), .div_isDivi(div_isDivi),
    .div_a(div_a), .div_b(div_b), .div_imm(div_imm),
    .div_qo(div_qo), .div_ro(div_ro), .div_dvByZr(div_dvByZr), .div_done(div_done),
    .wb_v(wb_v), .wb_tgt(wb_tgt), .wb_res(wb_res), .dbz_exc(dbz_exc), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // ---------------- divider model ----------------
  logic        hang;
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_d;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
    end else if (div_ld && !hang) begin
      m_busy = 1'b1;
      m_cnt  = LAT - 1;
      m_d    = div_isDivi ? div_imm : div_b;
      if (m_d == 64'd0) begin
        div_dvByZr <= 1'b1;
        div_qo     <= '1;
        div_ro     <= div_a;
      end else begin
        div_dvByZr <= 1'b0;
        if (div_sgn) begin
          div_qo <= $signed(div_a) / $signed(m_d);
          div_ro <= $signed(div_a) % $signed(m_d);
        end else begin
          div_qo <= div_a / m_d;
          div_ro <= div_a % m_d;
        end
      end
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        div_done <= 1'b1;
        m_busy   = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  // ---------------- monitors ----------------
  int ld_cnt = 0;
  int excl_viol = 0;
  always @(negedge clk) begin
    if (div_ld) ld_cnt++;
    if ((wb_v && dbz_exc) || (wb_v && tmo_err) || (dbz_exc && tmo_err)) excl_viol++;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // results of the last run_op
  int          o_lat, o_ld;
  logic        o_wb, o_dbz, o_tmo, o_stall1, o_stall_ev, o_isdivi, o_sgn, o_dld;
  logic [63:0] o_res, o_da;
  logic [5:0]  o_tgt;

  // Issue one op at a negedge and follow it until an output event, or until stall
  // drops after a flush/reset injected at cycle flush_at/rst_at (0 = none).
  // Cycle k is the k-th negedge after issue; LAUNCH is cycle 1 on a miss.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [5:0] tgt,
                        input int flush_at, input int rst_at);
    int  ld0;
    bit  stop;
    ld0 = ld_cnt;
    issue_v = 1'b1; issue_op = op; issue_a = a; issue_b = b; issue_imm = imm; issue_tgt = tgt;
    o_lat = 0; o_wb = 0; o_dbz = 0; o_tmo = 0; stop = 0;
    for (int k = 1; k <= 300 && !stop; k++) begin
      @(negedge clk);
      issue_v = 1'b0;
      if (k == 1) begin
        o_stall1 = stall; o_isdivi = div_isDivi; o_sgn = div_sgn;
      end
      if (wb_v || dbz_exc || tmo_err ||
          ((k > 1) && !stall && (((flush_at > 0) && (k > flush_at)) || ((rst_at > 0) && (k > rst_at))))) begin
        stop = 1;
        o_lat = k; o_wb = wb_v; o_dbz = dbz_exc; o_tmo = tmo_err;
        o_res = wb_res; o_tgt = wb_tgt; o_stall_ev = stall; o_da = div_a; o_dld = div_ld;
      end
      flush = (k == flush_at);
      rst   = (k == rst_at);
    end
    flush = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    o_ld = ld_cnt - ld0;
  endtask

  initial begin
    rst = 1'b1; hang = 1'b0; flush = 1'b0;
    issue_v = 1'b0; issue_op = '0; issue_a = '0; issue_b = '0; issue_imm = '0; issue_tgt = '0;
    div_qo = '0; div_ro = '0; div_dvByZr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_ld", div_ld, 0);
    chk("rst_wb_v", wb_v, 0);
    chk("rst_dbz", dbz_exc, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_wb_res", wb_res, 0);
    chk("rst_div_a", div_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // unsigned miss: 10005/27 = 370
    run_op(3'b000, 64'd10005, 64'd27, 64'd0, 6'd5, 0, 0);
    chk("u_wb", o_wb, 1);
    chk("u_res", o_res, 64'd370);
    chk("u_tgt", o_tgt, 6'd5);
    chk("u_lat", o_lat, LAT + 3);
    chk("u_ld", o_ld, 1);
    chk("u_stall_launch", o_stall1, 1);
    chk("u_stall_wb", o_stall_ev, 0);

    // same operands, MOD: cache hit, remainder 15 one cycle after issue
    run_op(3'b010, 64'd10005, 64'd27, 64'd0, 6'd7, 0, 0);
    chk("hit_wb", o_wb, 1);
    chk("hit_res", o_res, 64'd15);
    chk("hit_tgt", o_tgt, 6'd7);
    chk("hit_lat", o_lat, 1);
    chk("hit_ld", o_ld, 0);
    chk("hit_stall", o_stall1, 0);

    // signed immediate: -10005/27 = -370; register divisor 99 must be ignored
    run_op(3'b101, 64'hFFFF_FFFF_FFFF_D8EB, 64'd99, 64'd27, 6'd9, 0, 0);
    chk("simm_isdivi", o_isdivi, 1);
    chk("simm_sgn", o_sgn, 1);
    chk("simm_wb", o_wb, 1);
    chk("simm_res", o_res, 64'hFFFF_FFFF_FFFF_FE8E);
    chk("simm_ld", o_ld, 1);

    // divide by zero: exception, no writeback; cache invalidated
    run_op(3'b000, 64'd5, 64'd0, 64'd0, 6'd3, 0, 0);
    chk("dbz_exc", o_dbz, 1);
    chk("dbz_wb", o_wb, 0);
    chk("dbz_lat", o_lat, LAT + 3);
    run_op(3'b000, 64'd5, 64'd0, 64'd0, 6'd3, 0, 0);
    chk("dbz2_ld", o_ld, 1);
    chk("dbz2_exc", o_dbz, 1);
    // the signed-imm op was cached before the dbz; it must relaunch now
    run_op(3'b101, 64'hFFFF_FFFF_FFFF_D8EB, 64'd99, 64'd27, 6'd9, 0, 0);
    chk("inv_ld", o_ld, 1);
    chk("inv_res", o_res, 64'hFFFF_FFFF_FFFF_FE8E);

    // flush 10 cycles into WAIT: drain until done+1, no writeback, result cached
    run_op(3'b000, 64'd1000, 64'd7, 64'd0, 6'd4, 12, 0);
    chk("fl_wb", o_wb, 0);
    chk("fl_dbz", o_dbz, 0);
    chk("fl_lat", o_lat, LAT + 3);
    chk("fl_ld", o_ld, 1);
    run_op(3'b010, 64'd1000, 64'd7, 64'd0, 6'd6, 0, 0);
    chk("fl_hit_lat", o_lat, 1);
    chk("fl_hit_res", o_res, 64'd6);
    chk("fl_hit_ld", o_ld, 0);

    // watchdog: divider never completes; error 100 cycles after LAUNCH (cycle 1)
    hang = 1'b1;
    run_op(3'b000, 64'd77, 64'd3, 64'd0, 6'd2, 0, 0);
    hang = 1'b0;
    chk("wd_tmo", o_tmo, 1);
    chk("wd_wb", o_wb, 0);
    chk("wd_lat", o_lat, 101);
    chk("wd_stall", o_stall_ev, 0);

    // reset mid-WAIT
    run_op(3'b000, 64'd123456, 64'd1000, 64'd0, 6'd1, 0, 0);
    chk("pre_rst_res", o_res, 64'd123);
    run_op(3'b000, 64'd1000, 64'd7, 64'd0, 6'd8, 0, 20);
    chk("mrst_wb", o_wb, 0);
    chk("mrst_stall", o_stall_ev, 0);
    chk("mrst_ld", o_dld, 0);
    chk("mrst_res", o_res, 0);
    chk("mrst_div_a", o_da, 0);
    run_op(3'b010, 64'd123456, 64'd1000, 64'd0, 6'd11, 0, 0);
    chk("post_rst_ld", o_ld, 1);
    chk("post_rst_lat", o_lat, LAT + 3);
    chk("post_rst_res", o_res, 64'd456);
    chk("post_rst_tgt", o_tgt, 6'd11);

    chk("exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
